disp_bcd_loader: RTL and testbench
==================================

# disp_bcd_loader

Upstream feeder for the four-digit seven-segment scanner. Accepts display writes from the CPU memory-mapped I/O path, converts a 16-bit binary value to four BCD digits with a sequential double-dabble engine (or passes raw hex nibbles through), and presents the digits with a one-cycle load strobe. A one-deep pending buffer absorbs writes that arrive while a conversion is in progress.

## Interface
- MAX_DEC, 9999: largest value shown in decimal; larger values are flagged as overflow.
- OVF_DIGIT, 4'hE: digit value driven on all four digits on overflow.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0). Release is synchronous to clk.
- wr_en  input  1  single-cycle write request from the MMIO decoder.
- wr_data  input  16  value to display.
- hex_mode  input  1  sampled with wr_en. 1 = show wr_data as four raw hex nibbles; 0 = decimal.
- busy  output  1  high in the CONV and DONE states.
- ovf  output  1  sticky per update. 1 when the last completed decimal write exceeded MAX_DEC.
- l0, l1, l2, l3  output  4 each  digits. l0 is the rightmost/least significant digit. Held between updates.
- LEDCtrl  output  1  one-cycle pulse, coincident with the first cycle that new digits are valid.

## Operation
- States: IDLE, CONV, DONE.
- Reset values: state IDLE, l0..l3 = 0, LEDCtrl = 0, busy = 0, ovf = 0, pending empty, iteration counter = 0.
- Launching a job with value V and mode M:
  - If M = 1, go to DONE. Digits = V[3:0], V[7:4], V[11:8], V[15:12] on l0..l3. ovf = 0.
  - If M = 0 and V > MAX_DEC, go to DONE. All digits = OVF_DIGIT. ovf = 1.
  - Otherwise, load V[13:0] into the shift register, clear the 16-bit BCD accumulator, and go to CONV with counter = 0.
- IDLE: wr_en launches a job from wr_data and hex_mode.
- CONV: one double-dabble iteration per cycle.
  - Each iteration: every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1.
  - After iteration 14 (counter = 13), go to DONE. Digits = accumulator nibbles; ovf = 0.
- DONE: l0..l3 and ovf take their new values. LEDCtrl = 1 for exactly this cycle.
  - If pending is valid, launch the pending job and clear pending.
  - Else if wr_en, launch directly from the inputs.
  - Otherwise go to IDLE.
- Pending buffer:
  - wr_en in CONV stores {wr_data, hex_mode} into pending. A newer write overwrites older pending content (last write wins).
  - wr_en in DONE while pending is valid: the pending job launches and the new write becomes pending.
- Arithmetic: the accumulator is 16 bits. Each nibble add is 4-bit, with no carry between nibbles. Inputs ≤ 9999 never produce a nibble > 9.
- Digits never change except in the DONE cycle. Intermediate accumulator values never reach l0..l3.

## Timing
- Decimal, in range: wr_en high in cycle 0 (IDLE).
  - Cycles 1–14: CONV.
  - Cycle 15: DONE, new digits, LEDCtrl = 1.
  - Cycle 16: IDLE, busy = 0.
- Hex or overflow: wr_en in cycle 0. Cycle 1 is DONE with LEDCtrl = 1. Cycle 2 is IDLE.
- Back-to-back jobs launched from DONE: the next DONE follows 15 cycles later (decimal) or 1 cycle later (hex/overflow).
- LEDCtrl is never high on two consecutive cycles unless DONE→DONE occurs (hex/overflow chained). In that case it stays high for both cycles, and each cycle carries its own digits.
- Reset mid-operation: within the same cycle, the outputs return to their reset values. The in-flight job and the pending job are discarded, with no LEDCtrl pulse.
- wr_en during reset is ignored.

## Test plan
- Reset, then decimal write 1234 in cycle 0: cycle 15 has l3..l0 = 1,2,3,4, LEDCtrl = 1, ovf = 0. Cycle 16 has busy = 0 and digits held.
- Decimal write 9999: l3..l0 = 9,9,9,9 at cycle 15. Decimal write 10000: l3..l0 = E,E,E,E and ovf = 1 at cycle 1.
- Hex write 16'hBEEF: cycle 1 has l3..l0 = B,E,E,F, LEDCtrl = 1. Then decimal 0: cycle 15 has all digits 0 and ovf = 0.
- Decimal 42 in cycle 0, decimal 7 in cycle 5, decimal 9 in cycle 8:
  - Cycle 15: 0,0,4,2 with LEDCtrl.
  - Cycle 30: 0,0,0,9 with LEDCtrl.
  - 7 is never displayed.
  - Exactly two LEDCtrl pulses.
- Decimal 5678 in cycle 0, rst low in cycle 7, released in cycle 9: no LEDCtrl pulse. Digits are 0 from cycle 7, and busy = 0.
- Decimal 100 in cycle 0, hex 16'h00A5 in cycle 15 (the DONE cycle):
  - Cycle 15: 0,1,0,0.
  - Cycle 16: DONE with 0,0,A,5.
  - LEDCtrl high in cycles 15 and 16.

Source files
------------

// File: rtl/disp_bcd_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_bcd_loader_if
// Description : Write-side and display-side signal bundle for the BCD loader.
//               The master is the MMIO write path; the slave is the loader.
// Revision    : 1.0  initial release
// ============================================================================
interface disp_bcd_loader_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        hex_mode;
  logic        busy;
  logic        ovf;
  logic [3:0]  l0;
  logic [3:0]  l1;
  logic [3:0]  l2;
  logic [3:0]  l3;
  logic        LEDCtrl;

  modport master (
    output wr_en, wr_data, hex_mode,
    input  busy, ovf, l0, l1, l2, l3, LEDCtrl
  );

  modport slave (
    input  wr_en, wr_data, hex_mode,
    output busy, ovf, l0, l1, l2, l3, LEDCtrl
  );
endinterface
`default_nettype wire

// File: rtl/disp_bcd_loader.sv
`default_nettype none
// ============================================================================
// Module      : disp_bcd_loader
// Description : Converts a 16-bit display write into four digits (sequential
//               double-dabble for decimal, nibble pass-through for hex) and
//               presents them with a one-cycle load strobe. A one-deep pending
//               buffer holds the latest write that arrives mid-conversion.
// Revision    : 1.0  initial release
// ============================================================================
module disp_bcd_loader #(
  parameter int         MAX_DEC   = 9999,
  parameter logic [3:0] OVF_DIGIT = 4'hE
) (
  input  wire logic         clk,
  input  wire logic         rst,   // active-low, asynchronous assert
  disp_bcd_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] c_max_dec   = 16'(MAX_DEC);
  localparam logic [3:0]  c_last_iter = 4'd13;

  state_t      r_state,     w_state_nxt;
  logic [13:0] r_bin,       w_bin_nxt;
  logic [15:0] r_bcd,       w_bcd_nxt;
  logic [3:0]  r_cnt,       w_cnt_nxt;
  logic        r_pend_vld,  w_pend_vld_nxt;
  logic [15:0] r_pend_data, w_pend_data_nxt;
  logic        r_pend_hex,  w_pend_hex_nxt;
  logic [15:0] r_digits,    w_digits_nxt;
  logic        r_ovf,       w_ovf_nxt;

  logic        w_launch;
  logic [15:0] w_ld_data;
  logic        w_ld_hex;
  logic [15:0] w_adj;
  logic [15:0] w_shift_bcd;

  // Add-3 correction per BCD nibble; 4-bit adds, no carry between nibbles.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                              (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
  end

  // The next binary MSB enters the accumulator LSB on each shift.
  assign w_shift_bcd = {w_adj[14:0], r_bin[13]};

  // State and datapath registers; reset discards in-flight and pending jobs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_pend_hex  <= 1'b0;
      r_digits    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bin       <= w_bin_nxt;
      r_bcd       <= w_bcd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_pend_hex  <= w_pend_hex_nxt;
      r_digits    <= w_digits_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  // Next-state, conversion step, pending-buffer update and job launch.
  always_comb begin
    w_state_nxt     = r_state;
    w_bin_nxt       = r_bin;
    w_bcd_nxt       = r_bcd;
    w_cnt_nxt       = r_cnt;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_data_nxt = r_pend_data;
    w_pend_hex_nxt  = r_pend_hex;
    w_digits_nxt    = r_digits;
    w_ovf_nxt       = r_ovf;
    w_launch        = 1'b0;
    w_ld_data       = bus.wr_data;
    w_ld_hex        = bus.hex_mode;

    case (r_state)
      IDLE: begin
        if (bus.wr_en) begin
          w_launch = 1'b1;
        end
      end

      CONV: begin
        w_bcd_nxt = w_shift_bcd;
        w_bin_nxt = {r_bin[12:0], 1'b0};
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == c_last_iter) begin
          // Final iteration result goes straight to the digits so the
          // accumulator's intermediate values are never visible.
          w_state_nxt  = DONE;
          w_digits_nxt = w_shift_bcd;
          w_ovf_nxt    = 1'b0;
          w_cnt_nxt    = 4'd0;
        end
        // Last write wins while a conversion is running.
        if (bus.wr_en) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_data_nxt = bus.wr_data;
          w_pend_hex_nxt  = bus.hex_mode;
        end
      end

      DONE: begin
        if (r_pend_vld) begin
          // Older pending job goes first; a simultaneous write takes its slot.
          w_launch       = 1'b1;
          w_ld_data      = r_pend_data;
          w_ld_hex       = r_pend_hex;
          w_pend_vld_nxt = bus.wr_en;
          if (bus.wr_en) begin
            w_pend_data_nxt = bus.wr_data;
            w_pend_hex_nxt  = bus.hex_mode;
          end
        end else if (bus.wr_en) begin
          w_launch = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_launch) begin
      if (w_ld_hex) begin
        w_state_nxt  = DONE;
        w_digits_nxt = w_ld_data;
        w_ovf_nxt    = 1'b0;
      end else if (w_ld_data > c_max_dec) begin
        w_state_nxt  = DONE;
        w_digits_nxt = {4{OVF_DIGIT}};
        w_ovf_nxt    = 1'b1;
      end else begin
        w_state_nxt = CONV;
        w_bin_nxt   = w_ld_data[13:0];
        w_bcd_nxt   = '0;
        w_cnt_nxt   = 4'd0;
      end
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.LEDCtrl = (r_state == DONE);
  assign bus.ovf     = r_ovf;
  assign bus.l0      = r_digits[3:0];
  assign bus.l1      = r_digits[7:4];
  assign bus.l2      = r_digits[11:8];
  assign bus.l3      = r_digits[15:12];

endmodule
`default_nettype wire

// File: tb/tb_disp_bcd_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_bcd_loader
// Description : Directed self-checking bench for disp_bcd_loader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_disp_bcd_loader;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   led_cnt;

  disp_bcd_loader_if bus ();

  disp_bcd_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count load strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.LEDCtrl === 1'b1) led_cnt <= led_cnt + 1;
  end

  function automatic logic [15:0] digits();
    return {bus.l3, bus.l2, bus.l1, bus.l0};
  endfunction

  // Advance n cycles; returns 1 time unit after the active edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [15:0] d, input logic h);
    bus.wr_en    = 1'b1;
    bus.wr_data  = d;
    bus.hex_mode = h;
    tick(1);
    bus.wr_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.wr_en    = 1'b1;          // must be ignored during reset
    bus.wr_data  = 16'd1234;
    bus.hex_mode = 1'b1;
    tick(3);
    checks++;
    if (digits() !== 16'h0000 || bus.busy !== 1'b0 || bus.ovf !== 1'b0 || bus.LEDCtrl !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: digits=%h busy=%b ovf=%b led=%b required 0000 0 0 0",
               digits(), bus.busy, bus.ovf, bus.LEDCtrl);
    end
    bus.wr_en = 1'b0;
    rst       = 1'b1;
    tick(2);
    checks++;
    if (bus.busy !== 1'b0 || led_cnt !== 0) begin
      failures++;
      $display("FAIL reset_wr_ignored: busy=%b leds=%0d required 0 0", bus.busy, led_cnt);
    end
  endtask

  task automatic test_dec_1234();
    write(16'd1234, 1'b0);        // cycle 1
    tick(13);                     // cycle 14
    checks++;
    if (bus.LEDCtrl !== 1'b0 || bus.busy !== 1'b1 || digits() !== 16'h0000) begin
      failures++;
      $display("FAIL dec1234_c14: led=%b busy=%b digits=%h required 0 1 0000",
               bus.LEDCtrl, bus.busy, digits());
    end
    tick(1);                      // cycle 15
    checks++;
    if (digits() !== 16'h1234 || bus.LEDCtrl !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL dec1234_c15: digits=%h led=%b ovf=%b required 1234 1 0",
               digits(), bus.LEDCtrl, bus.ovf);
    end
    tick(1);                      // cycle 16
    checks++;
    if (bus.busy !== 1'b0 || bus.LEDCtrl !== 1'b0 || digits() !== 16'h1234) begin
      failures++;
      $display("FAIL dec1234_c16: busy=%b led=%b digits=%h required 0 0 1234",
               bus.busy, bus.LEDCtrl, digits());
    end
  endtask

  task automatic test_dec_max_and_overflow();
    write(16'd9999, 1'b0);
    tick(14);                     // cycle 15
    checks++;
    if (digits() !== 16'h9999 || bus.LEDCtrl !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL dec9999: digits=%h led=%b ovf=%b required 9999 1 0",
               digits(), bus.LEDCtrl, bus.ovf);
    end
    tick(2);
    write(16'd10000, 1'b0);       // cycle 1
    checks++;
    if (digits() !== 16'hEEEE || bus.ovf !== 1'b1 || bus.LEDCtrl !== 1'b1) begin
      failures++;
      $display("FAIL dec10000: digits=%h ovf=%b led=%b required EEEE 1 1",
               digits(), bus.ovf, bus.LEDCtrl);
    end
    tick(1);                      // cycle 2
    checks++;
    if (bus.busy !== 1'b0 || bus.ovf !== 1'b1 || digits() !== 16'hEEEE) begin
      failures++;
      $display("FAIL ovf_hold: busy=%b ovf=%b digits=%h required 0 1 EEEE",
               bus.busy, bus.ovf, digits());
    end
  endtask

  task automatic test_hex_then_zero();
    write(16'hBEEF, 1'b1);        // cycle 1
    checks++;
    if (digits() !== 16'hBEEF || bus.LEDCtrl !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL hex_beef: digits=%h led=%b ovf=%b required BEEF 1 0",
               digits(), bus.LEDCtrl, bus.ovf);
    end
    tick(2);
    write(16'd0, 1'b0);
    tick(14);                     // cycle 15
    checks++;
    if (digits() !== 16'h0000 || bus.ovf !== 1'b0 || bus.LEDCtrl !== 1'b1) begin
      failures++;
      $display("FAIL dec_zero: digits=%h ovf=%b led=%b required 0000 0 1",
               digits(), bus.ovf, bus.LEDCtrl);
    end
    tick(2);
  endtask

  task automatic test_pending();
    led_cnt = 0;
    write(16'd42, 1'b0);          // cycle 1
    tick(4);                      // cycle 5
    write(16'd7, 1'b0);           // cycle 6
    tick(2);                      // cycle 8
    write(16'd9, 1'b0);           // cycle 9
    tick(6);                      // cycle 15
    checks++;
    if (digits() !== 16'h0042 || bus.LEDCtrl !== 1'b1) begin
      failures++;
      $display("FAIL pend_c15: digits=%h led=%b required 0042 1", digits(), bus.LEDCtrl);
    end
    tick(14);                     // cycle 29
    checks++;
    if (digits() !== 16'h0042 || bus.LEDCtrl !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pend_c29: digits=%h led=%b busy=%b required 0042 0 1",
               digits(), bus.LEDCtrl, bus.busy);
    end
    tick(1);                      // cycle 30
    checks++;
    if (digits() !== 16'h0009 || bus.LEDCtrl !== 1'b1) begin
      failures++;
      $display("FAIL pend_c30: digits=%h led=%b required 0009 1", digits(), bus.LEDCtrl);
    end
    tick(20);
    checks++;
    if (led_cnt !== 2 || bus.busy !== 1'b0 || digits() !== 16'h0009) begin
      failures++;
      $display("FAIL pend_pulses: leds=%0d busy=%b digits=%h required 2 0 0009",
               led_cnt, bus.busy, digits());
    end
  endtask

  task automatic test_reset_mid();
    led_cnt = 0;
    write(16'd5678, 1'b0);        // cycle 1
    tick(6);                      // cycle 7
    rst = 1'b0;
    #1;
    checks++;
    if (digits() !== 16'h0000 || bus.busy !== 1'b0 || bus.LEDCtrl !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_c7: digits=%h busy=%b led=%b required 0000 0 0",
               digits(), bus.busy, bus.LEDCtrl);
    end
    tick(2);                      // cycle 9
    rst = 1'b1;
    tick(11);                     // cycle 20
    checks++;
    if (led_cnt !== 0 || bus.busy !== 1'b0 || digits() !== 16'h0000) begin
      failures++;
      $display("FAIL rstmid_after: leds=%0d busy=%b digits=%h required 0 0 0000",
               led_cnt, bus.busy, digits());
    end
  endtask

  task automatic test_back_to_back();
    write(16'd100, 1'b0);         // cycle 1
    tick(14);                     // cycle 15
    checks++;
    if (digits() !== 16'h0100 || bus.LEDCtrl !== 1'b1) begin
      failures++;
      $display("FAIL b2b_c15: digits=%h led=%b required 0100 1", digits(), bus.LEDCtrl);
    end
    write(16'h00A5, 1'b1);        // cycle 16
    checks++;
    if (digits() !== 16'h00A5 || bus.LEDCtrl !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_c16: digits=%h led=%b ovf=%b required 00A5 1 0",
               digits(), bus.LEDCtrl, bus.ovf);
    end
    tick(1);                      // cycle 17
    checks++;
    if (bus.LEDCtrl !== 1'b0 || bus.busy !== 1'b0 || digits() !== 16'h00A5) begin
      failures++;
      $display("FAIL b2b_c17: led=%b busy=%b digits=%h required 0 0 00A5",
               bus.LEDCtrl, bus.busy, digits());
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    led_cnt      = 0;
    rst          = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.hex_mode = 1'b0;
    test_reset();
    test_dec_1234();
    test_dec_max_and_overflow();
    test_hex_then_zero();
    test_pending();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
